// File: rtl/amax10_qsys_nios2_gen2_ocimem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : amax10_qsys_nios2_gen2_ocimem_pkg
// Brief    : Shared constants and types for the on-chip debug memory.
// Revision : 1.0 - initial release
// ============================================================================
package amax10_qsys_nios2_gen2_ocimem_pkg;

  // CPU word address of the monitor control/status register
  localparam logic [8:0] OCI_CTRL_ADDR = 9'h100;

  // Control/status register bit indices
  localparam int CTRL_READY = 0;
  localparam int CTRL_ERROR = 1;
  localparam int CTRL_GO    = 2;

  // Field positions inside the JTAG data word
  localparam int JDO_ADDR_HI = 33;
  localparam int JDO_ADDR_LO = 26;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_CLR     = 25;
  localparam int JDO_GO      = 24;

  // CPU slave port state
  typedef enum logic [0:0] {
    C_IDLE = 1'b0,
    C_DONE = 1'b1
  } cpu_state_t;

  // Kind of RAM operation a JTAG strobe queues
  typedef enum logic [0:0] {
    J_READ  = 1'b0,
    J_WRITE = 1'b1
  } jtag_op_t;

endpackage
`default_nettype wire

// File: rtl/amax10_qsys_nios2_gen2_ociram_sp.sv
`default_nettype none
// ============================================================================
// Module   : amax10_qsys_nios2_gen2_ociram_sp
// Brief    : Single-port synchronous RAM, byte enables, 1-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module amax10_qsys_nios2_gen2_ociram_sp #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_we,
  input  logic [DW/8-1:0]   i_be,
  input  logic [DW-1:0]     i_wdata,
  output logic [DW-1:0]     o_q
);

  localparam int c_DEPTH = 1 << AW;
  localparam int c_LANES = DW / 8;

  // Each byte lane owns its own storage so lane writes stay independent
  for (genvar i = 0; i < c_LANES; i++) begin : g_lane
    logic [7:0] r_mem [c_DEPTH];
    logic [7:0] r_q;

    // Lane write and read-first registered read
    always_ff @(posedge clk) begin
      if (i_we && i_be[i]) begin
        r_mem[i_addr] <= i_wdata[8*i +: 8];
      end
      r_q <= r_mem[i_addr];
    end

    assign o_q[8*i +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/amax10_qsys_nios2_gen2_ocimem.sv
`default_nettype none
// ============================================================================
// Module   : amax10_qsys_nios2_gen2_ocimem
// Brief    : Nios II debug monitor RAM and control register, shared between
//            the CPU debug slave and JTAG strobes (JTAG has priority).
// Revision : 1.0 - initial release
// ============================================================================
module amax10_qsys_nios2_gen2_ocimem
  import amax10_qsys_nios2_gen2_ocimem_pkg::*;
#(
  parameter int RAM_AW = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [8:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        debugaccess,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic        monitor_go
);

  // JTAG pending operation
  logic              r_jtag_pend;
  jtag_op_t          r_jtag_op;
  logic              r_jtag_incr;
  logic [RAM_AW-1:0] r_jtag_addr;
  logic [31:0]       r_jtag_data;
  logic              r_jtag_rd_done;
  logic [31:0]       r_mon_dreg;

  // Monitor status bits
  logic r_ready;
  logic r_error;
  logic r_go;

  // CPU port
  cpu_state_t  r_cpu_state;
  logic        r_cpu_ctrl_sel;
  logic        r_cpu_ram_ok;
  logic [2:0]  r_ctrl_rd;

  // RAM port
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_q;

  logic w_cpu_req;
  logic w_cpu_go;
  logic w_cpu_ctrl;
  logic w_cpu_ram_ok;
  logic w_ctrl_wr;
  logic w_unused;

  assign w_cpu_req    = read | write;
  assign w_cpu_go     = (r_cpu_state == C_IDLE) & w_cpu_req & ~r_jtag_pend;
  assign w_cpu_ctrl   = |(address & OCI_CTRL_ADDR);
  assign w_cpu_ram_ok = ~w_cpu_ctrl & debugaccess;
  assign w_ctrl_wr    = w_cpu_go & write & w_cpu_ctrl;
  assign w_unused     = ^{jdo[37:35], jdo[2:0]};

  // RAM port arbitration: a pending JTAG op owns the RAM for its cycle
  always_comb begin
    w_ram_addr  = address[RAM_AW-1:0];
    w_ram_we    = w_cpu_go & write & w_cpu_ram_ok;
    w_ram_be    = byteenable;
    w_ram_wdata = writedata;
    if (r_jtag_pend) begin
      w_ram_addr  = r_jtag_addr;
      w_ram_we    = (r_jtag_op == J_WRITE);
      w_ram_be    = 4'hF;
      w_ram_wdata = r_jtag_data;
    end
  end

  amax10_qsys_nios2_gen2_ociram_sp #(
    .AW (RAM_AW),
    .DW (32)
  ) u_ociram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  // JTAG strobe capture, op retirement with address increment, MonDReg load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jtag_pend    <= 1'b0;
      r_jtag_op      <= J_READ;
      r_jtag_incr    <= 1'b0;
      r_jtag_addr    <= '0;
      r_jtag_data    <= '0;
      r_jtag_rd_done <= 1'b0;
      r_mon_dreg     <= '0;
    end else begin
      r_jtag_rd_done <= r_jtag_pend & (r_jtag_op == J_READ);
      if (r_jtag_rd_done) begin
        r_mon_dreg <= w_ram_q;
      end
      if (r_jtag_pend) begin
        r_jtag_pend <= 1'b0;
        if (r_jtag_incr) begin
          r_jtag_addr <= r_jtag_addr + RAM_AW'(1);
        end
      end
      if (take_action_ocimem_a) begin
        r_jtag_pend <= 1'b1;
        r_jtag_op   <= J_READ;
        r_jtag_incr <= 1'b0;
        r_jtag_addr <= RAM_AW'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
      end else if (take_no_action_ocimem_a) begin
        r_jtag_pend <= 1'b1;
        r_jtag_op   <= J_READ;
        r_jtag_incr <= 1'b1;
      end else if (take_action_ocimem_b) begin
        r_jtag_pend <= 1'b1;
        r_jtag_op   <= J_WRITE;
        r_jtag_incr <= 1'b1;
        r_jtag_data <= jdo[JDO_DATA_HI:JDO_DATA_LO];
      end
    end
  end

  // Monitor status: CPU sets of ready/error beat JTAG clears, JTAG go beats CPU clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      if (w_ctrl_wr && writedata[CTRL_READY]) begin
        r_ready <= 1'b1;
      end else if (take_action_ocimem_a && jdo[JDO_CLR]) begin
        r_ready <= 1'b0;
      end
      if (w_ctrl_wr && writedata[CTRL_ERROR]) begin
        r_error <= 1'b1;
      end else if (take_action_ocimem_a && jdo[JDO_CLR]) begin
        r_error <= 1'b0;
      end
      if (take_action_ocimem_a && jdo[JDO_GO]) begin
        r_go <= 1'b1;
      end else if (w_ctrl_wr && writedata[CTRL_GO]) begin
        r_go <= 1'b0;
      end
    end
  end

  // CPU port FSM: access in the accept cycle, answer in C_DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_state    <= C_IDLE;
      r_cpu_ctrl_sel <= 1'b0;
      r_cpu_ram_ok   <= 1'b0;
      r_ctrl_rd      <= '0;
    end else begin
      case (r_cpu_state)
        C_IDLE: begin
          if (w_cpu_go) begin
            r_cpu_state            <= C_DONE;
            r_cpu_ctrl_sel         <= w_cpu_ctrl;
            r_cpu_ram_ok           <= w_cpu_ram_ok;
            r_ctrl_rd[CTRL_READY]  <= r_ready;
            r_ctrl_rd[CTRL_ERROR]  <= r_error;
            r_ctrl_rd[CTRL_GO]     <= r_go;
          end
        end
        C_DONE:  r_cpu_state <= C_IDLE;
        default: r_cpu_state <= C_IDLE;
      endcase
    end
  end

  assign waitrequest   = w_cpu_req & (r_cpu_state != C_DONE);
  assign readdata      = (r_cpu_state != C_DONE) ? 32'h0 :
                         r_cpu_ctrl_sel          ? {29'b0, r_ctrl_rd} :
                         r_cpu_ram_ok            ? w_ram_q : 32'h0;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;
  assign monitor_go    = r_go;

endmodule
`default_nettype wire
